// File: rtl/axi4_lite_master_slave.sv
// AXI4-Lite master driven by a one-cycle user strobe, wired point-to-point to a
// four-register AXI4-Lite slave. `ready` pulses when each transaction completes.
module axi4_lite_master_slave (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic [3:0]  addr,
  input  logic        write,
  input  logic [31:0] wdata,
  input  logic        transfer,
  output logic [31:0] rdata,
  output logic        ready
);

  logic [3:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  typedef enum logic [2:0] {
    StIdle,
    StWrAddrData,
    StWrResp,
    StRdAddr,
    StRdData
  } state_e;

  state_e state;

  // Master
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state   <= StIdle;
      AWADDR  <= '0;
      AWVALID <= 1'b0;
      WDATA   <= '0;
      WVALID  <= 1'b0;
      BREADY  <= 1'b0;
      ARADDR  <= '0;
      ARVALID <= 1'b0;
      RREADY  <= 1'b0;
      rdata   <= '0;
      ready   <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        StIdle: begin
          if (transfer) begin
            if (write) begin
              AWADDR  <= addr;
              WDATA   <= wdata;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              BREADY  <= 1'b1;
              state   <= StWrAddrData;
            end else begin
              ARADDR  <= addr;
              ARVALID <= 1'b1;
              RREADY  <= 1'b1;
              state   <= StRdAddr;
            end
          end
        end
        StWrAddrData: begin
          if (AWVALID && AWREADY) AWVALID <= 1'b0;
          if (WVALID && WREADY)   WVALID  <= 1'b0;
          // Each channel is done once its VALID has dropped or it handshakes now.
          if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) state <= StWrResp;
        end
        StWrResp: begin
          if (BVALID && BREADY) begin
            BREADY <= 1'b0;
            ready  <= 1'b1;
            state  <= StIdle;
          end
        end
        StRdAddr: begin
          if (ARVALID && ARREADY) begin
            ARVALID <= 1'b0;
            state   <= StRdData;
          end
        end
        StRdData: begin
          if (RVALID && RREADY) begin
            rdata  <= RDATA;
            RREADY <= 1'b0;
            ready  <= 1'b1;
            state  <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Slave
  logic [31:0] slv_reg [4];
  logic        aw_taken;
  logic        w_taken;
  logic [1:0]  aw_sel;
  logic [31:0] w_data;
  logic        aw_hs;
  logic        w_hs;
  logic        have_aw;
  logic        have_w;
  logic [1:0]  wr_sel;
  logic [31:0] wr_data;

  always_comb begin
    aw_hs   = AWVALID && AWREADY;
    w_hs    = WVALID && WREADY;
    have_aw = aw_hs || aw_taken;
    have_w  = w_hs || w_taken;
    wr_sel  = aw_taken ? aw_sel : AWADDR[3:2];
    wr_data = w_taken ? w_data : WDATA;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      aw_taken <= 1'b0;
      w_taken  <= 1'b0;
      aw_sel   <= '0;
      w_data   <= '0;
      BVALID   <= 1'b0;
      BRESP    <= 2'b00;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RDATA    <= '0;
      RRESP    <= 2'b00;
      for (int i = 0; i < 4; i++) slv_reg[i] <= '0;
    end else begin
      AWREADY <= AWVALID && !AWREADY && !aw_taken && !BVALID;
      WREADY  <= WVALID && !WREADY && !w_taken && !BVALID;

      if (have_aw && have_w) begin
        slv_reg[wr_sel] <= wr_data;
        BVALID          <= 1'b1;
        BRESP           <= 2'b00;
        aw_taken        <= 1'b0;
        w_taken         <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_taken <= 1'b1;
          aw_sel   <= AWADDR[3:2];
        end
        if (w_hs) begin
          w_taken <= 1'b1;
          w_data  <= WDATA;
        end
        if (BVALID && BREADY) BVALID <= 1'b0;
      end

      ARREADY <= ARVALID && !ARREADY && !RVALID;
      if (ARVALID && ARREADY) begin
        RVALID <= 1'b1;
        RDATA  <= slv_reg[ARADDR[3:2]];
        RRESP  <= 2'b00;
      end else if (RVALID && RREADY) begin
        RVALID <= 1'b0;
      end
    end
  end

  // Byte-offset bits are ignored by the register decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

endmodule

// File: tb/tb_axi4_lite_master_slave.sv
// Scoreboard bench for axi4_lite_master_slave: expected completions are queued
// at request time and matched against each `ready` pulse.
module tb_axi4_lite_master_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  addr;
  logic        write;
  logic [31:0] wdata;
  logic        transfer;
  logic [31:0] rdata;
  logic        ready;

  axi4_lite_master_slave dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .addr     (addr),
    .write    (write),
    .wdata    (wdata),
    .transfer (transfer),
    .rdata    (rdata),
    .ready    (ready)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    int          issued;
  } sb_entry_t;

  sb_entry_t   sb[$];
  logic [31:0] model [4];
  int          n_checks = 0;
  int          n_pass = 0;
  int          pcount = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  always @(posedge ACLK) pcount++;

  // Completion monitor: every ready pulse must match the oldest queued request.
  always @(negedge ACLK) begin
    if (ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 32'd1, 32'd0);
      end else begin
        sb_entry_t e;
        e = sb.pop_front();
        check("latency", pcount - e.issued - 1, 32'd3);
        if (!e.wr) check("rdata", rdata, e.data);
      end
    end
    if (dut.BVALID === 1'b1) check("bresp", {30'd0, dut.BRESP}, 32'd0);
    if (dut.RVALID === 1'b1) check("rresp", {30'd0, dut.RRESP}, 32'd0);
  end

  // Called at a negedge; returns at the negedge where the next request may start.
  task automatic issue(input logic wr, input logic [3:0] a, input logic [31:0] d);
    sb_entry_t e;
    transfer = 1'b1;
    write    = wr;
    addr     = a;
    wdata    = d;
    if (wr) model[a[3:2]] = d;
    e.wr     = wr;
    e.data   = model[a[3:2]];
    e.issued = pcount;
    sb.push_back(e);
    @(negedge ACLK);
    transfer = 1'b0;
    repeat (3) @(negedge ACLK);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) check(tag, dut.slv_reg[i], model[i]);
  endtask

  initial begin
    ARESETn  = 1'b0;
    transfer = 1'b0;
    write    = 1'b0;
    addr     = '0;
    wdata    = '0;
    for (int i = 0; i < 4; i++) model[i] = '0;

    @(negedge ACLK);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_handshakes",
          {22'd0, dut.AWVALID, dut.WVALID, dut.BREADY, dut.ARVALID, dut.RREADY,
           dut.AWREADY, dut.WREADY, dut.BVALID, dut.ARREADY, dut.RVALID}, 32'd0);
    check("rst_bus_data", dut.RDATA, 32'd0);
    check_regs("rst_reg");
    ARESETn = 1'b1;
    @(negedge ACLK);

    for (int i = 0; i < 4; i++) issue(1'b1, 4'(i * 4), 32'(i + 1));
    @(negedge ACLK);
    check_regs("wr_reg");

    for (int i = 0; i < 4; i++) issue(1'b0, 4'(i * 4), 32'd0);

    issue(1'b1, 4'h5, 32'hDEADBEEF);
    issue(1'b0, 4'h4, 32'd0);
    check("unaligned_reg1", dut.slv_reg[1], 32'hDEADBEEF);

    // Second strobe one cycle after a write request must be dropped.
    begin
      sb_entry_t e;
      transfer = 1'b1;
      write    = 1'b1;
      addr     = 4'hC;
      wdata    = 32'h44;
      model[3] = 32'h44;
      e.wr     = 1'b1;
      e.data   = 32'h44;
      e.issued = pcount;
      sb.push_back(e);
      @(negedge ACLK);
      addr  = 4'h0;
      wdata = 32'hFF;
      @(negedge ACLK);
      transfer = 1'b0;
      repeat (4) @(negedge ACLK);
    end
    check_regs("busy_reg");

    // Reset while the write sits in WR_RESP: no completion may appear.
    transfer = 1'b1;
    write    = 1'b1;
    addr     = 4'h8;
    wdata    = 32'h55;
    @(negedge ACLK);
    transfer = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = '0;
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    check_regs("midrst_reg");
    @(negedge ACLK);

    issue(1'b1, 4'h8, 32'h77);
    issue(1'b0, 4'h8, 32'd0);
    issue(1'b0, 4'h0, 32'd0);
    repeat (4) @(negedge ACLK);
    check("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
